seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Parametrised multiplexed 7-segment scan driver for DIGITS digits with built-in prescaler.
//  Runs from the system clock; no external slow clock is needed.
//  Latches the digit data once per frame so a refresh never shows a mix of old and new values.
//  Adds inter-digit dead time (anti-ghosting), per-digit blanking, per-digit decimal point and optional blink.
//  Sits between the application display logic and the board's seg_en/seg_out pins.
// PARAMETERS
//  DIGITS       8        number of digits scanned (2..8)
//  SCAN_DIV     100000   clk cycles per digit slot (100 MHz -> 1 kHz per digit)
//  DEAD_CYCLES  200      cycles blanked at start of every slot; must be >=1 and <SCAN_DIV
//  BLINK_FRAMES 64       frames per blink phase (used only with SEG_SCAN_BLINK_EN)
// PORTS
//  clk          in   1          system clock
//  rst          in   1          synchronous, active-high reset
//  en           in   1          display enable; 0 blanks all digits, counters keep running
//  content      in   4*DIGITS   hex nibble per digit; digit i = content[4i+3:4i]
//  dp           in   DIGITS     decimal point per digit, 1 = lit
//  blank_mask   in   DIGITS     1 = digit i dark for the whole frame
//  blink_mask   in   DIGITS     1 = digit i blinks; present in both builds
//  seg_en       out  DIGITS     one-hot digit select, active-high
//  seg_out      out  8          {a,b,c,d,e,f,g,dp}, active-high
//  frame_start  out  1          1-cycle pulse when a new frame's data is latched
// BEHAVIOUR
//  - Reset state: seg_en=0, seg_out=0, frame_start=0, prescaler cnt=0, digit idx=0, shadow regs=0.
//  - Prescaler cnt runs 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and idx advances.
//  - idx runs 0..DIGITS-1 and wraps to 0.
//  - Frame latch: on any edge where cnt==0 && idx==0 (including the first cycle after rst falls):
//      shadow <= {content, dp, blank_mask, blink_mask};
//      frame_start <= 1 (high for exactly 1 cycle).
//    Input changes at any other time do not affect the frame in progress.
//  - Outputs are registered, with 1-cycle latency from (cnt, idx, shadow).
//  - Visibility: lit = en && cnt>=DEAD_CYCLES && !blank_sh[idx] && !blink_off[idx].
//      lit:     seg_en = 1<<idx, seg_out = {decode(content_sh[idx]), dp_sh[idx]}.
//      not lit: seg_en = 0, seg_out = 0.
//  - DEAD_CYCLES>=1 guarantees the shadow load never coincides with a lit slot.
//  - en falling mid-slot: outputs go to 0 on the next edge. en rising: the current slot lights on the next edge if past the dead time.
//  - rst mid-frame: all state returns to reset values on that edge. A new frame latches on the first cycle after rst falls.
//  - Decode (0-F): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71, in {g..a} order mapped to {a..g} on seg_out[7:1].
//  - Frame period = DIGITS*SCAN_DIV cycles.
// CONFIGURATION
//  SEG_SCAN_BLINK_EN defined:
//    Frame counter counts latched frames 0..BLINK_FRAMES-1. At wrap, blink phase toggles; reset phase = on.
//    During the off phase, digits with blink_sh=1 are dark.
//  SEG_SCAN_BLINK_EN undefined:
//    No frame counter or phase register; blink_off is tied to 0 and blink_mask is ignored.
// STRUCTURE
//  - Package seg_pkg: SEG_* decode constants (16 x 7-bit), SEG_OFF=8'h00, function onehot(idx, DIGITS).
//  - Sub-module hex7_decode: combinational 4-bit -> 7-bit lookup, shared with the other display blocks.
//  - Top holds the prescaler, idx counter, shadow regs, blink counter and output registers.
// TESTING  (DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2)
//  1. Reset, content=16'h3210, dp=0, en=1 -> frame_start pulse 1 cycle after rst falls.
//     Slot 0 cycles 2..7: seg_en=0001, seg_out=8'hFC. Then 0010/8'h60, 0100/8'hDA, 1000/8'hF2. Period 32 cycles.
//  2. Change content to 16'hFFFF mid-slot 2 -> digits 2,3 keep old values until the next frame_start, then show 8'h8E.
//  3. dp=4'b0100, blank_mask=4'b0001 -> slot 0 dark all 8 cycles; digit 2 seg_out=8'hDB.
//  4. Drop en for 5 cycles inside slot 1 lit window -> seg_en=0 one cycle later; relights one cycle after en=1.
//  5. Assert rst for 1 cycle mid-slot 3 -> all outputs 0 next edge; idx restarts at 0; new frame_start follows.
//  6. [BLINK_EN] blink_mask=4'b1000 -> digit 3 lit 2 frames, dark 2 frames, repeating; without the macro always lit.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment constants and helpers.
// Segment patterns are stored as {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [7:0] SEG_OFF = 8'h00;

  function automatic logic [7:0] onehot(
    input logic [2:0] idx,
    input int         digits
  );
    logic [7:0] r;
    r = '0;
    if (int'(idx) < digits)
      r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to 7-segment lookup.
// Output order is {g,f,e,d,c,b,a}.
module hex7_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = '0;
    unique case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with prescaler and frame latch.
// Define SEG_SCAN_BLINK_EN to enable per-digit blinking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int DEAD_CYCLES  = 200,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   content,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [DIGITS-1:0]     seg_en,
  output logic [7:0]            seg_out,
  output logic                  frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] content_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic [DIGITS-1:0]   blank_sh;

  logic                load;
  logic                lit;
  logic                blink_off;
  logic [3:0]          nib;
  logic [6:0]          seg7;
  logic [6:0]          seg_rev;
  logic [7:0]          sel;
  logic [DIGITS-1:0]   seg_en_d;
  logic [7:0]          seg_out_d;

  assign load = (cnt == '0) && (idx == '0);
  assign nib  = content_sh[{idx, 2'b00} +: 4];

  hex7_decode u_dec (
    .hex (nib),
    .seg (seg7)
  );

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [DIGITS-1:0] blink_sh;
  logic [FW-1:0]     fcnt;
  logic              phase_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_sh <= '0;
      fcnt     <= '0;
      phase_on <= 1'b1;
    end else if (load) begin
      blink_sh <= blink_mask;
      if (fcnt == FRM_LAST) begin
        fcnt     <= '0;
        phase_on <= ~phase_on;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign blink_off = blink_sh[idx] & ~phase_on;
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, BLINK_FRAMES[0]};
  assign blink_off    = 1'b0;
`endif

  always_comb begin
    lit = en && (cnt >= CNT_DEAD)
        && !blank_sh[idx] && !blink_off;
    for (int i = 0; i < 7; i++)
      seg_rev[6-i] = seg7[i];
    sel       = onehot(3'(idx), DIGITS);
    seg_en_d  = '0;
    seg_out_d = SEG_OFF;
    if (lit) begin
      seg_en_d  = sel[DIGITS-1:0];
      seg_out_d = {seg_rev, dp_sh[idx]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      content_sh  <= '0;
      dp_sh       <= '0;
      blank_sh    <= '0;
      seg_en      <= '0;
      seg_out     <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      if (load) begin
        content_sh <= content;
        dp_sh      <= dp;
        blank_sh   <= blank_mask;
      end
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      seg_en  <= seg_en_d;
      seg_out <= seg_out_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, 8-cycle slots).
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] content;
  logic [3:0]  dp;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [3:0]  seg_en;
  logic [7:0]  seg_out;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(
    .DIGITS       (4),
    .SCAN_DIV     (8),
    .DEAD_CYCLES  (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .content     (content),
    .dp          (dp),
    .blank_mask  (blank_mask),
    .blink_mask  (blink_mask),
    .seg_en      (seg_en),
    .seg_out     (seg_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [3:0] ee,
    input logic [7:0] eo,
    input logic       ef
  );
    checks++;
    assert (seg_en === ee) else begin
      errors++;
      $error("FAIL %s seg_en=%b exp=%b", tag, seg_en, ee);
    end
    checks++;
    assert (seg_out === eo) else begin
      errors++;
      $error("FAIL %s seg_out=%h exp=%h", tag, seg_out, eo);
    end
    checks++;
    assert (frame_start === ef) else begin
      errors++;
      $error("FAIL %s frame_start=%b exp=%b", tag, frame_start, ef);
    end
  endtask

  // Steps through cycles c0..c1 of slot s; lit cycles are c>=2.
  task automatic slot(
    input string      tag,
    input int         s,
    input int         c0,
    input int         c1,
    input logic [7:0] val,
    input logic       lit_ok
  );
    logic [3:0] ee;
    logic [7:0] eo;
    logic       ef;
    for (int c = c0; c <= c1; c++) begin
      tick();
      ee = 4'b0000;
      eo = 8'h00;
      if (lit_ok && c >= 2) begin
        ee = 4'b0001 << s;
        eo = val;
      end
      ef = (s == 0) && (c == 0);
      chk($sformatf("%s_s%0d_c%0d", tag, s, c), ee, eo, ef);
    end
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    content    = 16'h3210;
    dp         = 4'b0000;
    blank_mask = 4'b0000;
    blink_mask = 4'b0000;
    tick();
    tick();
    tick();
    chk("reset", 4'b0000, 8'h00, 1'b0);
    rst = 1'b0;

    // Frame 1: basic scan
    slot("f1", 0, 0, 7, 8'hFC, 1'b1);
    slot("f1", 1, 0, 7, 8'h60, 1'b1);
    slot("f1", 2, 0, 7, 8'hDA, 1'b1);
    slot("f1", 3, 0, 7, 8'hF2, 1'b1);

    // Frame 2: content change mid-slot 2 must not leak in
    slot("f2", 0, 0, 7, 8'hFC, 1'b1);
    slot("f2", 1, 0, 7, 8'h60, 1'b1);
    slot("f2", 2, 0, 3, 8'hDA, 1'b1);
    content = 16'hFFFF;
    slot("f2", 2, 4, 7, 8'hDA, 1'b1);
    slot("f2", 3, 0, 7, 8'hF2, 1'b1);

    // Frame 3: new content shown everywhere
    slot("f3", 0, 0, 7, 8'h8E, 1'b1);
    slot("f3", 1, 0, 7, 8'h8E, 1'b1);
    slot("f3", 2, 0, 7, 8'h8E, 1'b1);
    slot("f3", 3, 0, 3, 8'h8E, 1'b1);
    content    = 16'h3210;
    dp         = 4'b0100;
    blank_mask = 4'b0001;
    slot("f3", 3, 4, 7, 8'h8E, 1'b1);

    // Frame 4: blanked digit 0, decimal point on digit 2
    slot("f4", 0, 0, 7, 8'h00, 1'b0);
    slot("f4", 1, 0, 7, 8'h60, 1'b1);
    slot("f4", 2, 0, 7, 8'hDB, 1'b1);
    slot("f4", 3, 0, 3, 8'hF2, 1'b1);
    dp         = 4'b0000;
    blank_mask = 4'b0000;
    slot("f4", 3, 4, 7, 8'hF2, 1'b1);

    // Frame 5: enable dropped for 5 cycles in slot 1, then reset in slot 3
    slot("f5", 0, 0, 7, 8'hFC, 1'b1);
    slot("f5", 1, 0, 1, 8'h60, 1'b1);
    en = 1'b0;
    slot("f5_enoff", 1, 2, 6, 8'h60, 1'b0);
    en = 1'b1;
    slot("f5_enon", 1, 7, 7, 8'h60, 1'b1);
    slot("f5", 2, 0, 7, 8'hDA, 1'b1);
    slot("f5", 3, 0, 3, 8'hF2, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_mid", 4'b0000, 8'h00, 1'b0);
    rst = 1'b0;

    // Frame 6: restart from digit 0 with a new latch
    slot("f6", 0, 0, 7, 8'hFC, 1'b1);
    slot("f6", 1, 0, 7, 8'h60, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
